// File: rtl/axi_slave_ram.sv
// rtl/axi_slave_ram.sv - AXI4 INCR-burst slave in front of a byte-strobed 32-bit word RAM
module axi_slave_ram #(
    parameter int          DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        ACLK,
    input  logic        RST,
    input  logic        AXI_S_ARID,
    input  logic [31:0] AXI_S_ARADDR,
    input  logic [7:0]  AXI_S_ARLEN,
    input  logic [2:0]  AXI_S_ARSIZE,
    input  logic [1:0]  AXI_S_ARBURST,
    input  logic        AXI_S_ARVALID,
    output logic        AXI_S_ARREADY,
    output logic        AXI_S_RID,
    output logic [31:0] AXI_S_RDATA,
    output logic [1:0]  AXI_S_RRESP,
    output logic        AXI_S_RLAST,
    output logic        AXI_S_RVALID,
    input  logic        AXI_S_RREADY,
    input  logic        AXI_S_AWID,
    input  logic [31:0] AXI_S_AWADDR,
    input  logic [7:0]  AXI_S_AWLEN,
    input  logic [2:0]  AXI_S_AWSIZE,
    input  logic [1:0]  AXI_S_AWBURST,
    input  logic        AXI_S_AWVALID,
    output logic        AXI_S_AWREADY,
    input  logic [31:0] AXI_S_WDATA,
    input  logic [3:0]  AXI_S_WSTRB,
    input  logic        AXI_S_WLAST,
    input  logic        AXI_S_WVALID,
    output logic        AXI_S_WREADY,
    output logic        AXI_S_BID,
    output logic [1:0]  AXI_S_BRESP,
    output logic        AXI_S_BVALID,
    input  logic        AXI_S_BREADY
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   ram_rdata_q;
    logic          ram_re, ram_we;

    r_state_t      r_state_q, r_state_d;
    logic          r_id_q, r_id_d, r_err_q, r_err_d, r_bad_q, r_bad_d;
    logic [31:0]   r_addr_q, r_addr_d;
    logic [7:0]    r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic          arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [31:0]   r_idx;
    logic          r_in_range;

    w_state_t      w_state_q, w_state_d;
    logic          w_id_q, w_id_d, w_err_q, w_err_d, w_werr_q, w_werr_d;
    logic [31:0]   w_addr_q, w_addr_d;
    logic [7:0]    w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic          awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [31:0]   w_idx;
    logic          w_in_range, w_beat_err;

    assign r_idx      = (r_addr_q - BASE) >> 2;
    assign r_in_range = r_idx < 32'(DEPTH);
    assign w_idx      = (w_addr_q - BASE) >> 2;
    assign w_in_range = w_idx < 32'(DEPTH);

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_err_d   = r_err_q;
        r_bad_d   = r_bad_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        ram_re    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (AXI_S_ARVALID && arready_q) begin
                    arready_d = 1'b0;
                    r_id_d    = AXI_S_ARID;
                    r_addr_d  = AXI_S_ARADDR;
                    r_len_d   = AXI_S_ARLEN;
                    r_err_d   = (AXI_S_ARSIZE != 3'd2) || (AXI_S_ARBURST != 2'b01);
                    r_cnt_d   = 8'd0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                ram_re    = 1'b1;
                r_bad_d   = r_err_q || !r_in_range;
                rresp_d   = (r_err_q || !r_in_range) ? 2'b10 : 2'b00;
                rlast_d   = (r_cnt_q == r_len_q);
                rvalid_d  = 1'b1;
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (AXI_S_RREADY) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_addr_d  = r_addr_q + 32'd4;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d  = w_state_q;
        w_id_d     = w_id_q;
        w_err_d    = w_err_q;
        w_werr_d   = w_werr_q;
        w_addr_d   = w_addr_q;
        w_len_d    = w_len_q;
        w_cnt_d    = w_cnt_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        ram_we     = 1'b0;
        w_beat_err = w_werr_q;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (AXI_S_AWVALID && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_id_d    = AXI_S_AWID;
                    w_addr_d  = AXI_S_AWADDR;
                    w_len_d   = AXI_S_AWLEN;
                    w_err_d   = (AXI_S_AWSIZE != 3'd2) || (AXI_S_AWBURST != 2'b01);
                    w_werr_d  = (AXI_S_AWSIZE != 3'd2) || (AXI_S_AWBURST != 2'b01);
                    w_cnt_d   = 8'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (AXI_S_WVALID && wready_q) begin
                    ram_we     = !w_err_q && w_in_range;
                    // A misplaced WLAST only poisons the response; AWLEN still sets the length.
                    w_beat_err = w_werr_q || !w_in_range ||
                                 (AXI_S_WLAST != (w_cnt_q == w_len_q));
                    w_werr_d   = w_beat_err;
                    if (w_cnt_q == w_len_q) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = w_beat_err ? 2'b10 : 2'b00;
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d  = w_cnt_q + 8'd1;
                        w_addr_d = w_addr_q + 32'd4;
                    end
                end
            end
            W_RESP: begin
                if (AXI_S_BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (AXI_S_WSTRB[b]) mem[w_idx[AW-1:0]][8*b +: 8] <= AXI_S_WDATA[8*b +: 8];
            end
        end
        if (ram_re) ram_rdata_q <= mem[r_idx[AW-1:0]];
    end

    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            r_state_q <= R_IDLE;
            r_id_q    <= 1'b0;
            r_err_q   <= 1'b0;
            r_bad_q   <= 1'b0;
            r_addr_q  <= 32'd0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            w_state_q <= W_IDLE;
            w_id_q    <= 1'b0;
            w_err_q   <= 1'b0;
            w_werr_q  <= 1'b0;
            w_addr_q  <= 32'd0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_err_q   <= r_err_d;
            r_bad_q   <= r_bad_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_err_q   <= w_err_d;
            w_werr_q  <= w_werr_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // The RAM output register is not reset, so gate it to keep RDATA at 0 outside valid good beats.
    assign AXI_S_RDATA   = (rvalid_q && !r_bad_q) ? ram_rdata_q : 32'h0;
    assign AXI_S_ARREADY = arready_q;
    assign AXI_S_RID     = r_id_q;
    assign AXI_S_RRESP   = rresp_q;
    assign AXI_S_RLAST   = rlast_q;
    assign AXI_S_RVALID  = rvalid_q;
    assign AXI_S_AWREADY = awready_q;
    assign AXI_S_WREADY  = wready_q;
    assign AXI_S_BID     = w_id_q;
    assign AXI_S_BRESP   = bresp_q;
    assign AXI_S_BVALID  = bvalid_q;
endmodule

// File: tb/tb_axi_slave_ram.sv
// tb/tb_axi_slave_ram.sv - randomized bench for axi_slave_ram against an array reference model
module tb_axi_slave_ram;
    logic        ACLK = 1'b0;
    logic        RST  = 1'b0;
    logic        AXI_S_ARID = 1'b0;
    logic [31:0] AXI_S_ARADDR = '0;
    logic [7:0]  AXI_S_ARLEN = '0;
    logic [2:0]  AXI_S_ARSIZE = 3'd2;
    logic [1:0]  AXI_S_ARBURST = 2'b01;
    logic        AXI_S_ARVALID = 1'b0;
    logic        AXI_S_ARREADY;
    logic        AXI_S_RID;
    logic [31:0] AXI_S_RDATA;
    logic [1:0]  AXI_S_RRESP;
    logic        AXI_S_RLAST;
    logic        AXI_S_RVALID;
    logic        AXI_S_RREADY = 1'b0;
    logic        AXI_S_AWID = 1'b0;
    logic [31:0] AXI_S_AWADDR = '0;
    logic [7:0]  AXI_S_AWLEN = '0;
    logic [2:0]  AXI_S_AWSIZE = 3'd2;
    logic [1:0]  AXI_S_AWBURST = 2'b01;
    logic        AXI_S_AWVALID = 1'b0;
    logic        AXI_S_AWREADY;
    logic [31:0] AXI_S_WDATA = '0;
    logic [3:0]  AXI_S_WSTRB = '0;
    logic        AXI_S_WLAST = 1'b0;
    logic        AXI_S_WVALID = 1'b0;
    logic        AXI_S_WREADY;
    logic        AXI_S_BID;
    logic [1:0]  AXI_S_BRESP;
    logic        AXI_S_BVALID;
    logic        AXI_S_BREADY = 1'b0;

    localparam int WORDS = 1024;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_mem [WORDS];
    logic [31:0] wr_data [256];
    logic [3:0]  wr_strb [256];

    axi_slave_ram #(.DEPTH(WORDS), .BASE(32'h0)) dut (
        .ACLK(ACLK), .RST(RST),
        .AXI_S_ARID(AXI_S_ARID), .AXI_S_ARADDR(AXI_S_ARADDR), .AXI_S_ARLEN(AXI_S_ARLEN),
        .AXI_S_ARSIZE(AXI_S_ARSIZE), .AXI_S_ARBURST(AXI_S_ARBURST),
        .AXI_S_ARVALID(AXI_S_ARVALID), .AXI_S_ARREADY(AXI_S_ARREADY),
        .AXI_S_RID(AXI_S_RID), .AXI_S_RDATA(AXI_S_RDATA), .AXI_S_RRESP(AXI_S_RRESP),
        .AXI_S_RLAST(AXI_S_RLAST), .AXI_S_RVALID(AXI_S_RVALID), .AXI_S_RREADY(AXI_S_RREADY),
        .AXI_S_AWID(AXI_S_AWID), .AXI_S_AWADDR(AXI_S_AWADDR), .AXI_S_AWLEN(AXI_S_AWLEN),
        .AXI_S_AWSIZE(AXI_S_AWSIZE), .AXI_S_AWBURST(AXI_S_AWBURST),
        .AXI_S_AWVALID(AXI_S_AWVALID), .AXI_S_AWREADY(AXI_S_AWREADY),
        .AXI_S_WDATA(AXI_S_WDATA), .AXI_S_WSTRB(AXI_S_WSTRB), .AXI_S_WLAST(AXI_S_WLAST),
        .AXI_S_WVALID(AXI_S_WVALID), .AXI_S_WREADY(AXI_S_WREADY),
        .AXI_S_BID(AXI_S_BID), .AXI_S_BRESP(AXI_S_BRESP), .AXI_S_BVALID(AXI_S_BVALID),
        .AXI_S_BREADY(AXI_S_BREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic axi_write(input logic id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input int wlast_beat);
        logic        berr;
        logic [1:0]  exp_resp;
        logic [31:0] a, idx;
        int          i, cyc;
        berr     = (size != 3'd2) || (burst != 2'b01);
        exp_resp = (berr || wlast_beat != len) ? 2'b10 : 2'b00;
        for (int k = 0; k <= len; k++) begin
            a   = addr + 32'(4 * k);
            idx = a >> 2;
            if (idx >= WORDS) exp_resp = 2'b10;
            else if (!berr)
                for (int b = 0; b < 4; b++)
                    if (wr_strb[k][b]) ref_mem[idx[9:0]][8*b +: 8] = wr_data[k][8*b +: 8];
        end
        @(negedge ACLK);
        AXI_S_AWID = id; AXI_S_AWADDR = addr; AXI_S_AWLEN = 8'(len);
        AXI_S_AWSIZE = size; AXI_S_AWBURST = burst; AXI_S_AWVALID = 1'b1;
        cyc = 0;
        while (!AXI_S_AWREADY && cyc < 1000) begin @(negedge ACLK); cyc++; end
        check_eq("aw_ready", 32'(AXI_S_AWREADY), 32'd1);
        i = 0; cyc = 0;
        while (i <= len && cyc < 2000) begin
            @(negedge ACLK); cyc++;
            AXI_S_AWVALID = 1'b0;
            AXI_S_WVALID  = ($urandom_range(0, 3) != 0);
            AXI_S_WDATA   = wr_data[i];
            AXI_S_WSTRB   = wr_strb[i];
            AXI_S_WLAST   = (i == wlast_beat);
            if (AXI_S_WVALID && AXI_S_WREADY) i++;
        end
        check_eq("w_beats", 32'(i), 32'(len + 1));
        cyc = 0;
        do begin
            @(negedge ACLK); cyc++;
            AXI_S_WVALID = 1'b0; AXI_S_WLAST = 1'b0;
            AXI_S_BREADY = 1'($urandom_range(0, 1));
        end while (!(AXI_S_BVALID && AXI_S_BREADY) && cyc < 1000);
        check_eq("bvalid", 32'(AXI_S_BVALID), 32'd1);
        check_eq("bresp", 32'(AXI_S_BRESP), 32'(exp_resp));
        check_eq("bid", 32'(AXI_S_BID), 32'(id));
        @(negedge ACLK);
        AXI_S_BREADY = 1'b0;
        check_eq("b_done", 32'(AXI_S_BVALID), 32'd0);
    endtask

    task automatic axi_read(input logic id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input logic rnd_ready);
        logic        berr, stalled, held_last;
        logic [31:0] a, idx, exp_data, held_data;
        logic [1:0]  exp_resp;
        int          beat, cyc;
        berr = (size != 3'd2) || (burst != 2'b01);
        @(negedge ACLK);
        AXI_S_ARID = id; AXI_S_ARADDR = addr; AXI_S_ARLEN = 8'(len);
        AXI_S_ARSIZE = size; AXI_S_ARBURST = burst; AXI_S_ARVALID = 1'b1;
        cyc = 0;
        while (!AXI_S_ARREADY && cyc < 1000) begin @(negedge ACLK); cyc++; end
        check_eq("ar_ready", 32'(AXI_S_ARREADY), 32'd1);
        beat = 0; cyc = 0; stalled = 1'b0; held_data = '0; held_last = 1'b0;
        while (beat <= len && cyc < 3000) begin
            @(negedge ACLK); cyc++;
            AXI_S_ARVALID = 1'b0;
            AXI_S_RREADY  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (AXI_S_RVALID) begin
                if (stalled) begin
                    check_eq("r_hold_data", AXI_S_RDATA, held_data);
                    check_eq("r_hold_last", 32'(AXI_S_RLAST), 32'(held_last));
                end
                if (AXI_S_RREADY) begin
                    a   = addr + 32'(4 * beat);
                    idx = a >> 2;
                    if (berr || idx >= WORDS) begin
                        exp_data = 32'h0; exp_resp = 2'b10;
                    end else begin
                        exp_data = ref_mem[idx[9:0]]; exp_resp = 2'b00;
                    end
                    check_eq("rdata", AXI_S_RDATA, exp_data);
                    check_eq("rresp", 32'(AXI_S_RRESP), 32'(exp_resp));
                    check_eq("rlast", 32'(AXI_S_RLAST), 32'(beat == len));
                    check_eq("rid", 32'(AXI_S_RID), 32'(id));
                    beat++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = AXI_S_RDATA;
                    held_last = AXI_S_RLAST;
                end
            end
        end
        check_eq("r_beats", 32'(beat), 32'(len + 1));
        @(negedge ACLK);
        AXI_S_RREADY = 1'b0;
        check_eq("r_idle", 32'(AXI_S_RVALID), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int          beat, cyc, len;
        logic        rv_seen;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;

        #1 RST = 1'b1;
        #2;
        check_eq("rst_arready", 32'(AXI_S_ARREADY), 32'd0);
        check_eq("rst_awready", 32'(AXI_S_AWREADY), 32'd0);
        check_eq("rst_wready", 32'(AXI_S_WREADY), 32'd0);
        check_eq("rst_rvalid", 32'(AXI_S_RVALID), 32'd0);
        check_eq("rst_bvalid", 32'(AXI_S_BVALID), 32'd0);
        check_eq("rst_rdata", AXI_S_RDATA, 32'd0);
        repeat (3) @(negedge ACLK);
        RST = 1'b0;
        @(posedge ACLK); #1;
        check_eq("rel_arready", 32'(AXI_S_ARREADY), 32'd1);
        check_eq("rel_awready", 32'(AXI_S_AWREADY), 32'd1);

        // Fill the whole RAM so every later read has a defined model value.
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 256; k++) begin wr_data[k] = $urandom; wr_strb[k] = 4'hF; end
            axi_write(1'b0, 32'(blk * 1024), 255, 3'd2, 2'b01, 255);
        end

        for (int k = 0; k < 4; k++) begin wr_data[k] = 32'hA0 + 32'(k); wr_strb[k] = 4'hF; end
        axi_write(1'b1, 32'h100, 3, 3'd2, 2'b01, 3);
        axi_read(1'b1, 32'h100, 3, 3'd2, 2'b01, 1'b0);

        wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
        axi_write(1'b0, 32'h200, 0, 3'd2, 2'b01, 0);
        wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
        axi_write(1'b1, 32'h200, 0, 3'd2, 2'b01, 0);
        axi_read(1'b0, 32'h200, 0, 3'd2, 2'b01, 1'b0);

        axi_read(1'b1, 32'h0, 255, 3'd2, 2'b01, 1'b1);

        axi_read(1'b0, 32'hFFC, 1, 3'd2, 2'b01, 1'b0);
        wr_data[0] = 32'hCAFE_0001; wr_data[1] = 32'hCAFE_0002;
        wr_strb[0] = 4'hF;          wr_strb[1] = 4'hF;
        axi_write(1'b1, 32'hFFC, 1, 3'd2, 2'b01, 0);
        axi_read(1'b1, 32'hFFC, 0, 3'd2, 2'b01, 1'b0);

        axi_read(1'b1, 32'h100, 0, 3'd2, 2'b10, 1'b0);
        wr_data[0] = 32'hDEAD_BEEF; wr_data[1] = 32'h0BAD_F00D;
        axi_write(1'b0, 32'h300, 1, 3'd1, 2'b01, 1);
        axi_read(1'b0, 32'h300, 1, 3'd2, 2'b01, 1'b0);

        for (int k = 0; k < 16; k++) begin wr_data[k] = $urandom; wr_strb[k] = 4'hF; end
        fork
            axi_write(1'b1, 32'h800, 15, 3'd2, 2'b01, 15);
            axi_read(1'b0, 32'h400, 15, 3'd2, 2'b01, 1'b1);
        join
        axi_read(1'b1, 32'h800, 15, 3'd2, 2'b01, 1'b0);

        for (int it = 0; it < 20; it++) begin
            addr  = 32'($urandom_range(0, 1030)) << 2;
            len   = $urandom_range(0, 15);
            size  = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
            burst = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b01;
            for (int k = 0; k <= len; k++) begin wr_data[k] = $urandom; wr_strb[k] = 4'($urandom); end
            axi_write(1'($urandom), addr, len, size, burst,
                      ($urandom_range(0, 7) == 0) ? len - 1 : len);
            axi_read(1'($urandom), addr, len, 3'd2, 2'b01, 1'($urandom));
        end

        @(negedge ACLK);
        AXI_S_ARID = 1'b0; AXI_S_ARADDR = 32'h0; AXI_S_ARLEN = 8'd7;
        AXI_S_ARSIZE = 3'd2; AXI_S_ARBURST = 2'b01; AXI_S_ARVALID = 1'b1;
        cyc = 0;
        while (!AXI_S_ARREADY && cyc < 100) begin @(negedge ACLK); cyc++; end
        beat = 0; cyc = 0; rv_seen = 1'b0;
        while (!rv_seen && cyc < 200) begin
            @(negedge ACLK); cyc++;
            AXI_S_ARVALID = 1'b0;
            if (AXI_S_RVALID && beat == 2) begin
                AXI_S_RREADY = 1'b0;
                rv_seen = 1'b1;
            end else begin
                AXI_S_RREADY = 1'b1;
                if (AXI_S_RVALID) beat++;
            end
        end
        check_eq("mid_rvalid_pre", 32'(AXI_S_RVALID), 32'd1);
        #2 RST = 1'b1;
        #1;
        check_eq("mid_rvalid", 32'(AXI_S_RVALID), 32'd0);
        check_eq("mid_arready", 32'(AXI_S_ARREADY), 32'd0);
        check_eq("mid_bvalid", 32'(AXI_S_BVALID), 32'd0);
        @(negedge ACLK);
        @(negedge ACLK);
        RST = 1'b0;
        @(posedge ACLK); #1;
        check_eq("mid_rel_arready", 32'(AXI_S_ARREADY), 32'd1);
        axi_read(1'b1, 32'h0, 7, 3'd2, 2'b01, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_slave_ram.md
Name: axi_slave_ram

Overview:
AXI4-full slave (responder) with a 32-bit word RAM behind it. It pairs with the team's AXI master FIFO interface in simulation and in on-chip scratch-memory configurations. It accepts INCR bursts of 1..256 beats on independent read and write paths, supports byte strobes, and returns OKAY/SLVERR responses.

Parameters:
DEPTH, 1024, RAM size in 32-bit words (power of two, >= 2)
BASE, 32'h0000_0000, byte address mapped to word 0

Ports:
ACLK  in  1  clock; all logic on rising edge
RST  in  1  asynchronous, active-high reset
AXI_S_ARID  in  1  read ID
AXI_S_ARADDR  in  32  read start byte address
AXI_S_ARLEN  in  8  beats-1
AXI_S_ARSIZE  in  3  must be 3'h2
AXI_S_ARBURST  in  2  must be 2'h1 (INCR)
AXI_S_ARVALID  in  1  / AXI_S_ARREADY  out  1
AXI_S_RID  out  1 / AXI_S_RDATA  out  32 / AXI_S_RRESP  out  2 / AXI_S_RLAST  out  1
AXI_S_RVALID  out  1 / AXI_S_RREADY  in  1
AXI_S_AWID  in  1 / AXI_S_AWADDR  in  32 / AXI_S_AWLEN  in  8 / AXI_S_AWSIZE  in  3 / AXI_S_AWBURST  in  2
AXI_S_AWVALID  in  1 / AXI_S_AWREADY  out  1
AXI_S_WDATA  in  32 / AXI_S_WSTRB  in  4 / AXI_S_WLAST  in  1 / AXI_S_WVALID  in  1 / AXI_S_WREADY  out  1
AXI_S_BID  out  1 / AXI_S_BRESP  out  2 / AXI_S_BVALID  out  1 / AXI_S_BREADY  in  1

Behaviour:
- Reset (async assert, sync release): all outputs 0; both FSMs idle; RAM contents unchanged (undefined at power-up).
- Word index = (addr - BASE) >> 2, 32-bit unsigned; beat in range iff index < DEPTH. Address advances +4 per beat; no wrap, no 4KB check.
- Burst error: SIZE != 2 or BURST != INCR -> every beat of that burst is SLVERR (2'b10), burst still runs ARLEN/AWLEN+1 beats, no RAM write.
- RAM: one read port, one byte-enabled write port, 1-cycle read latency, read-during-write same word returns old data. No ordering between read and write channels.
- Read FSM R_IDLE / R_FETCH / R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID: latch id, addr, len, error; beat count=0 -> R_FETCH.
  - R_FETCH: issue RAM read of current index -> R_DATA.
  - R_DATA: RVALID=1; RDATA = RAM data (0 if out of range or burst error); RRESP = OKAY (2'b00), SLVERR if out of range or error; RLAST = (count == len); RID = latched id. Outputs hold stable while RREADY=0.
  - On RREADY: if RLAST -> R_IDLE, else count+1, addr+4 -> R_FETCH.
  - Throughput is 1 beat per 2 cycles. First RVALID appears 2 cycles after AR handshake.
- Write FSM W_IDLE / W_DATA / W_RESP:
  - W_IDLE: AWREADY=1, WREADY=0. On AWVALID: latch id, addr, len, error; count=0; werr=error -> W_DATA.
  - W_DATA: WREADY=1. On WVALID: if in range and no burst error, write WDATA with WSTRB byte enables; out-of-range beat sets werr. If WLAST != (count == len), set werr. When count == len -> W_RESP; else count+1, addr+4. Burst length is set by AWLEN, never by WLAST.
  - W_RESP: BVALID=1, BID = latched id, BRESP = werr ? 2'b10 : 2'b00. On BREADY -> W_IDLE.
  - A new AW is accepted only after B completes (one write outstanding). W beats arriving before AW are stalled (WREADY=0).
- Read and write FSMs run fully concurrently.

Test Plan:
- Reset mid-burst: assert RST during R_DATA beat 3 of 8 -> RVALID, ARREADY, BVALID go 0 immediately; after release ARREADY=1 next cycle.
- Write AWADDR=0x100, AWLEN=3, data 0xA0..0xA3, WSTRB=4'hF, WLAST on beat 4 -> BRESP=00, BID echoes AWID. Then read same range, ARLEN=3 -> RDATA 0xA0..0xA3, RLAST only on 4th beat, RRESP=00.
- Byte strobe: word 0x200 holds 0x11223344; write 0xAABBCCDD with WSTRB=4'b0101 -> read returns 0x11BB33DD.
- RREADY toggled 0/1 randomly over a 256-beat read -> no beat lost or duplicated, RDATA/RLAST stable while stalled, exactly one RLAST.
- Out of range (DEPTH=1024): read ARADDR=0xFFC, ARLEN=1 -> beat 1 OKAY with data, beat 2 RDATA=0, RRESP=10. Write AWLEN=1 with WLAST asserted on beat 1 -> 2 beats still consumed, BRESP=10.
- ARBURST=2'h2 (WRAP), ARLEN=0 -> single beat, RRESP=10, RDATA=0. Concurrent 16-beat read and 16-beat write to disjoint addresses both complete with correct data.
